cordic_phase_gen: RTL and testbench
===================================

Name: cordic_phase_gen

Overview:
- Upstream stage of the CORDIC sin/cos core: generates the 32-bit phase word and fixed Xin/Yin seed that drive CORDIC.
- Phase-accumulator NCO: one new angle per clock, run for a programmed sample count or until stopped.
- Tracks the CORDIC pipeline latency so downstream logic knows which Xout/Yout samples are valid, and signals completion.

Parameters:
- PHASE_W, 32, angle/tuning-word width; 2^32 = 360 degrees.
- SZ, 16, Xin/Yin width, matching CORDIC SZ.
- LATENCY, 16, CORDIC clock latency from angle/Xin/Yin to Xout/Yout; must be >= 1.
- INIT_X, 19429, Xin seed (32000/1.647, pre-compensating CORDIC gain).

Ports:
- CLK_100MHZ  in  1  system clock; all logic rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- stop  in  1  single-cycle request to end a run early; sampled only in RUN.
- ftw  in  PHASE_W  frequency tuning word (phase step per sample), latched on accepted start.
- count  in  16  number of samples to issue, latched on accepted start; 0 = continuous until stop.
- angle  out  PHASE_W  phase to CORDIC angle input.
- Xin  out  SZ  CORDIC X seed.
- Yin  out  SZ  CORDIC Y seed.
- angle_valid  out  1  angle is a live sample this cycle.
- out_valid  out  1  CORDIC Xout/Yout valid this cycle (angle_valid delayed LATENCY cycles).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- All outputs and state are registered. RESET (async, any time, including mid-run) forces:
  - IDLE; angle=0, Xin=INIT_X, Yin=0.
  - angle_valid=0, out_valid=0, busy=0, done=0.
  - Latched ftw/count and the issued counter cleared; valid shift register cleared.
- Xin/Yin hold INIT_X/0 constantly after reset.
- States:
  - IDLE:
    - angle holds 0.
    - start=1: latch ftw and count, clear the issued counter, go to RUN. The next cycle presents angle=0 with angle_valid=1.
    - stop is ignored.
  - RUN:
    - Each cycle after the first: angle <= angle + ftw_latched, mod 2^PHASE_W (natural wrap, no saturation).
    - Issued counter increments on every angle_valid cycle.
    - count!=0 and the sample being presented is number count: next cycle enter DRAIN, angle_valid=0. Exactly count valid angles are issued.
    - stop=1: the current cycle's sample still counts; next cycle DRAIN.
    - stop on the final-count cycle: single transition to DRAIN, no extra sample.
    - start is ignored.
  - DRAIN:
    - angle holds the last issued value; angle_valid=0.
    - Wait until the valid shift register is all zero, then assert done for one cycle and go to IDLE. angle returns to 0 in that same cycle.
    - start and stop are ignored.
- out_valid: LATENCY-deep shift register of angle_valid. out_valid first rises exactly LATENCY cycles after the first angle_valid; its high-cycle count always equals the issued sample count.
- done asserts the cycle after the final out_valid high cycle.
- busy=1 from the first RUN cycle through the cycle before done; busy=0 while done=1.
- Earliest new start: the cycle after done.

Test Plan:
- Reset, then idle 10 cycles -> angle=0, Xin=19429, Yin=0, angle_valid=out_valid=busy=done=0.
- ftw=0x00B60B60, count=360, start pulse:
  - angle_valid high for 360 consecutive cycles.
  - angle sequence 0x00000000, 0x00B60B60, 0x016C16C0, ..., last 0xFF49F3A0.
  - out_valid high 360 cycles, first rise 16 cycles after the first angle_valid.
  - done pulses once, the cycle after the last out_valid.
- Wrap check: ftw=0x40000000, count=6 -> angles 0x00000000, 0x40000000, 0x80000000, 0xC0000000, 0x00000000, 0x40000000; then DRAIN holds 0x40000000.
- Continuous mode:
  - ftw=0x01000000, count=0; stop on the 10th angle_valid cycle -> exactly 10 samples, 10 out_valid cycles, done once.
  - A start pulse during RUN/DRAIN has no effect.
- count=1 -> single angle_valid cycle (angle=0), single out_valid cycle, done the following cycle, busy high LATENCY+1 cycles total.
- Assert RESET mid-RUN (sample 50 of 360) -> same cycle: angle=0, angle_valid=out_valid=busy=0, no done pulse. A fresh start afterwards restarts from angle 0.

Source files
------------

// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: phase-accumulator NCO that feeds a CORDIC sin/cos core.
// It issues one angle per clock for a programmed sample count (or until
// stopped), holds the fixed Xin/Yin seed, and tracks the CORDIC pipeline
// latency so downstream logic knows which Xout/Yout samples are valid.
module cordic_phase_gen #(
    parameter int PHASE_W = 32,
    parameter int SZ      = 16,
    parameter int LATENCY = 16,
    parameter int INIT_X  = 19429
) (
    input  logic               CLK_100MHZ,
    input  logic               RESET,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] ftw,
    input  logic [15:0]        count,
    output logic [PHASE_W-1:0] angle,
    output logic [SZ-1:0]      Xin,
    output logic [SZ-1:0]      Yin,
    output logic               angle_valid,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [SZ-1:0] SEED_X = SZ'(INIT_X);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [PHASE_W-1:0]   angle_next;
    logic                 angle_valid_next;
    logic                 busy_next;
    logic                 done_next;
    logic [PHASE_W-1:0]   ftw_lat, ftw_lat_next;
    logic [15:0]          count_lat, count_lat_next;
    logic [15:0]          issued, issued_next;
    logic [LATENCY-1:0]   valid_sr, valid_sr_next;

    // The delay line shifts angle_valid in at the bottom; its top bit is out_valid.
    generate
        if (LATENCY == 1) begin : g_sr1
            assign valid_sr_next = angle_valid;
        end else begin : g_srn
            assign valid_sr_next = {valid_sr[LATENCY-2:0], angle_valid};
        end
    endgenerate

    assign out_valid = valid_sr[LATENCY-1];

    // Register all state and outputs; the seed is constant after reset.
    always_ff @(posedge CLK_100MHZ or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            angle       <= '0;
            Xin         <= SEED_X;
            Yin         <= '0;
            angle_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ftw_lat     <= '0;
            count_lat   <= '0;
            issued      <= '0;
            valid_sr    <= '0;
        end else begin
            state       <= state_next;
            angle       <= angle_next;
            Xin         <= SEED_X;
            Yin         <= '0;
            angle_valid <= angle_valid_next;
            busy        <= busy_next;
            done        <= done_next;
            ftw_lat     <= ftw_lat_next;
            count_lat   <= count_lat_next;
            issued      <= issued_next;
            valid_sr    <= valid_sr_next;
        end
    end

    // Next-state and next-output decode. In RUN, 'issued' counts samples
    // already presented before this one, so issued+1 is the current sample.
    // DRAIN finishes when the delay line will be empty after this edge, which
    // puts done in the cycle right after the last out_valid.
    always_comb begin
        state_next       = state;
        angle_next       = angle;
        angle_valid_next = 1'b0;
        busy_next        = 1'b0;
        done_next        = 1'b0;
        ftw_lat_next     = ftw_lat;
        count_lat_next   = count_lat;
        issued_next      = issued;
        case (state)
            IDLE: begin
                angle_next = '0;
                if (start) begin
                    ftw_lat_next     = ftw;
                    count_lat_next   = count;
                    issued_next      = '0;
                    state_next       = RUN;
                    angle_valid_next = 1'b1;
                    busy_next        = 1'b1;
                end
            end
            RUN: begin
                busy_next   = 1'b1;
                issued_next = issued + 16'd1;
                if (stop || ((count_lat != 16'd0) && (issued + 16'd1 == count_lat))) begin
                    state_next = DRAIN;
                end else begin
                    angle_valid_next = 1'b1;
                    angle_next       = angle + ftw_lat;
                end
            end
            DRAIN: begin
                if (valid_sr_next == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                    angle_next = '0;
                end else begin
                    busy_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                angle_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb_cordic_phase_gen: directed vectors for the CORDIC phase generator.
module tb_cordic_phase_gen;

    localparam int LAT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] ftw = '0;
    logic [15:0] count = '0;
    logic [31:0] angle;
    logic [15:0] Xin;
    logic [15:0] Yin;
    logic        angle_valid;
    logic        out_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    cordic_phase_gen #(
        .PHASE_W(32), .SZ(16), .LATENCY(LAT), .INIT_X(19429)
    ) dut (
        .CLK_100MHZ(clk), .RESET(rst), .start(start), .stop(stop),
        .ftw(ftw), .count(count), .angle(angle), .Xin(Xin), .Yin(Yin),
        .angle_valid(angle_valid), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Start one run and watch it until a few cycles past done.
    task automatic run_case(input string tag, input logic [31:0] f, input logic [15:0] c,
                            input int stop_at, input int exp_n, input logic [31:0] exp_last);
        int cyc = 0, n_av = 0, n_ov = 0, first_av = -1, first_ov = -1, last_ov = -1;
        int n_done = 0, done_cyc = -1, busy_cnt = 0, post = 0, last_av_cyc = -100;
        logic stop_now;
        logic [31:0] exp_angle = 32'h0;
        logic [31:0] drain_angle = 32'hFFFF_FFFF;
        logic [31:0] done_angle = 32'hFFFF_FFFF;
        logic busy_at_done = 1'b1;
        ftw = f; count = c; start = 1'b1;
        tick();
        start = 1'b0; ftw = 32'hDEAD_BEEF; count = 16'd5;
        while (cyc < 2000 && post < 4) begin
            stop_now = 1'b0;
            if (angle_valid) begin
                check({tag, " angle"}, angle, exp_angle);
                exp_angle = exp_angle + f;
                n_av++;
                last_av_cyc = cyc;
                if (first_av < 0) first_av = cyc;
                if (n_av == stop_at) stop_now = 1'b1;
            end
            if (out_valid) begin
                n_ov++;
                if (first_ov < 0) first_ov = cyc;
                last_ov = cyc;
            end
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; done_angle = angle; busy_at_done = busy;
                end
            end else if (n_done == 0) begin
                drain_angle = angle;
            end
            if (n_done > 0) post++;
            stop = stop_now;
            start = busy && !done && (cyc == 3 || cyc == last_av_cyc + 3);
            tick();
            cyc++;
        end
        stop = 1'b0; start = 1'b0;
        check({tag, " n_angle_valid"}, 32'(n_av), 32'(exp_n));
        check({tag, " first_av"}, 32'(first_av), 32'd0);
        check({tag, " contiguous"}, 32'(last_av_cyc - first_av + 1), 32'(exp_n));
        check({tag, " n_out_valid"}, 32'(n_ov), 32'(exp_n));
        check({tag, " latency"}, 32'(first_ov - first_av), 32'(LAT));
        check({tag, " n_done"}, 32'(n_done), 32'd1);
        check({tag, " done_after_ov"}, 32'(done_cyc), 32'(last_ov + 1));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(done_cyc));
        check({tag, " busy_at_done"}, 32'(busy_at_done), 32'd0);
        check({tag, " drain_angle"}, drain_angle, exp_last);
        check({tag, " done_angle"}, done_angle, 32'h0);
        $display("run %s: samples=%0d out_valid=%0d done_cycle=%0d", tag, n_av, n_ov, done_cyc);
    endtask

    initial begin
        int k;
        int n;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("reset angle", angle, 32'h0);
        check("reset Xin", 32'(Xin), 32'd19429);
        check("reset Yin", 32'(Yin), 32'd0);
        check("reset angle_valid", 32'(angle_valid), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        $display("reset/idle: angle=0x%08h Xin=%0d Yin=%0d", angle, Xin, Yin);

        run_case("deg360", 32'h00B6_0B60, 16'd360, 0, 360, 32'hFF49_F3A0);
        run_case("wrap", 32'h4000_0000, 16'd6, 0, 6, 32'h4000_0000);
        run_case("cont_stop", 32'h0100_0000, 16'd0, 10, 10, 32'h0900_0000);
        run_case("count1", 32'h1234_5678, 16'd1, 0, 1, 32'h0);

        // Reset in the middle of a run, while sample 50 is on the output.
        ftw = 32'h00B6_0B60; count = 16'd360; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        k = 0;
        while (k < 200 && n < 50) begin
            if (angle_valid) n++;
            if (n < 50) tick();
            k++;
        end
        check("midrun reached 50", 32'(n), 32'd50);
        #2 rst = 1'b1;
        #1;
        check("midrun angle", angle, 32'h0);
        check("midrun angle_valid", 32'(angle_valid), 32'd0);
        check("midrun out_valid", 32'(out_valid), 32'd0);
        check("midrun busy", 32'(busy), 32'd0);
        check("midrun done", 32'(done), 32'd0);
        tick();
        check("inreset done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("postreset idle valid", 32'(angle_valid), 32'd0);
        check("postreset idle done", 32'(done), 32'd0);
        $display("midrun reset: angle=0x%08h busy=%0d", angle, busy);

        run_case("restart", 32'h1000_0000, 16'd3, 0, 3, 32'h2000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
